cache_controller: RTL and testbench
===================================

# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache controller between the MEM stage and the SRAM controller. It answers MEM-stage loads and stores and drives `ready`. The pipeline uses the inverse of `ready` as `mem_freeze`, which stalls every stage including the PC register in IF. A hit completes in the request cycle. A miss or any store holds `ready` low until the SRAM controller acknowledges.

## Interface
Parameters:
- `SETS`, 64: number of sets; index width is log2(SETS) = 6.
- `BASE_ADDR`, 1024: start of the data address space; subtracted from every address.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `rd_en` input 1: MEM-stage load request; held stable while `ready`=0.
- `wr_en` input 1: MEM-stage store request; held stable while `ready`=0.
- `addr` input 32: byte address, word aligned.
- `wdata` input 32: store data.
- `rdata` output 32: load data; valid when `ready`=1 and `rd_en`=1.
- `ready` output 1: request complete; the pipeline freezes while it is 0.
- `sram_rd_en` output 1: line read request to the SRAM controller.
- `sram_wr_en` output 1: word write request to the SRAM controller.
- `sram_addr` output 32: SRAM address, equal to `addr`; forced line-aligned for reads.
- `sram_wdata` output 32: SRAM write data, equal to `wdata`.
- `sram_rdata` input 64: returned line; `[31:0]` is the even word, `[63:32]` is the odd word.
- `sram_ready` input 1: one-cycle SRAM acknowledge.

## Operation
- Address split, with a = `addr` − `BASE_ADDR`:
  - word select = a[2]
  - index = a[8:3]
  - tag = a[18:9], 10 bits
- Per set, two ways. Each way holds valid (1b), tag (10b) and data (2×32b). Each set also holds one LRU bit, which names the least-recently-used way.
- States: IDLE, READ_MISS, WRITE.
- IDLE:
  - No request: `ready`=1.
  - `rd_en` and a hit in way w: `rdata` = selected word, `ready`=1 combinationally, and LRU = ~w at the edge.
  - `rd_en` and a miss: `ready`=0, go to READ_MISS.
  - `wr_en`: `ready`=0, go to WRITE. On a hit in way w, the selected word is updated and LRU = ~w at this edge. On a miss, the cache is unchanged.
  - `rd_en` and `wr_en` together is illegal. `wr_en` wins.
- READ_MISS:
  - `sram_rd_en`=1 and `sram_addr` = {`addr`[31:3],3'b0}.
  - On `sram_ready`, the victim is filled with tag, valid=1 and `sram_rdata`. The victim is the invalid way, way 0 first; if both ways are valid, it is the LRU way.
  - In the same cycle, `rdata` = the requested half of `sram_rdata`, `ready`=1, LRU = ~victim. Return to IDLE.
- WRITE:
  - `sram_wr_en`=1.
  - On `sram_ready`: `ready`=1, return to IDLE.
- `sram_rd_en` and `sram_wr_en` are never both 1.
- `rdata` = 0 whenever it is not valid.

## Timing
- Reset values:
  - state IDLE
  - all valid bits and LRU bits 0
  - `sram_rd_en`=`sram_wr_en`=0
  - `rdata`=0
  - `ready`=1 when no request is present
- Read hit: 0-cycle latency, no freeze.
- Read miss: `ready` rises in the same cycle as `sram_ready`. Freeze length equals SRAM latency plus 1 cycle.
- Store: always write-through. Freeze length equals SRAM latency plus 1 cycle, on hit or miss.
- `rst` mid-miss or mid-write: immediate return to IDLE, SRAM requests dropped, all valid bits cleared, no partial fill.
- A request that drops while in READ_MISS or WRITE is a protocol violation. The controller still finishes the SRAM transaction.
- A back-to-back request in the cycle after `ready` returns to 1 is evaluated from IDLE and sees the just-filled line.

## Structure
- Package `cache_pkg` holds:
  - state enum {IDLE, READ_MISS, WRITE}
  - TAG_W=10, IDX_W=6 constants
  - the address-split helper functions
- Sub-module `cache_mem` holds the valid, tag, data and LRU arrays. It provides:
  - two combinational read ports (way 0 and way 1 at an index)
  - a synchronous write port (way, word-or-line, LRU update)
  - an asynchronous clear on `rst`
- The top level holds the FSM, hit compare, victim select and output muxing.

## Test plan
- Cold read of 1024: `sram_rd_en` with `sram_addr`=1024. Return `sram_rdata`={32'd7,32'd5} after 3 cycles. Expect `rdata`=5 and `ready`=1 in the ack cycle. A following read of 1028 hits with `rdata`=7 and `ready`=1 with no SRAM request.
- Store 8192 to 1024 after it is cached: `sram_wr_en` with `sram_wdata`=8192, and `ready`=0 until ack. A following read of 1024 hits and returns 8192.
- Store to uncached 1100: SRAM write is issued. A following read of 1100 misses, which shows no allocation.
- LRU eviction: read 1024, 1536 and 2048 (same index, three tags) in turn. The third fill replaces the 1024 line. Re-reading 1536 hits; re-reading 1024 misses.
- Assert `rst` two cycles into a read miss: `sram_rd_en` drops immediately and `ready`=1. The same read afterwards misses again.
- Assert `rd_en` and `wr_en` together: the block performs the store path only.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the two-way set-associative data cache controller.
// Holds the FSM state encoding, the tag/index widths and the helpers that
// split a base-relative byte address into word select, set index and tag.
package cache_pkg;

  localparam int unsigned TAG_W = 10;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE
  } state_t;

  // The argument is the address with BASE_ADDR already removed.
  function automatic logic addr_word(input logic [31:0] a);
    return a[2];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
    return a[8:3];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[18:9];
  endfunction

endpackage

// File: rtl/cache_mem.sv
// Storage for the two-way cache: per-way valid, tag and two-word data line,
// plus one LRU bit per set naming the least-recently-used way.
// Ports:
//   clk, rst           clock; asynchronous active-high clear of valid and LRU
//   idx                set addressed by both read ports and the write port
//   rd_valid0/1, rd_tag0/1, rd_line0/1, rd_lru
//                      combinational read of both ways and the LRU bit
//   wr_line_en         fill a whole line (data, tag, valid=1) into wr_way
//   wr_word_en         overwrite one word (wr_word_sel) of wr_way
//   wr_tag, wr_line, wr_word   write data
//   lru_en, lru_val    LRU bit update for the set
module cache_mem
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output logic             rd_valid0,
  output logic             rd_valid1,
  output logic [TAG_W-1:0] rd_tag0,
  output logic [TAG_W-1:0] rd_tag1,
  output logic [63:0]      rd_line0,
  output logic [63:0]      rd_line1,
  output logic             rd_lru,
  input  logic             wr_line_en,
  input  logic             wr_word_en,
  input  logic             wr_way,
  input  logic             wr_word_sel,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_line,
  input  logic [31:0]      wr_word,
  input  logic             lru_en,
  input  logic             lru_val
);

  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [63:0]      data_q  [2][SETS];

  assign rd_valid0 = valid_q[0][idx];
  assign rd_valid1 = valid_q[1][idx];
  assign rd_tag0   = tag_q[0][idx];
  assign rd_tag1   = tag_q[1][idx];
  assign rd_line0  = data_q[0][idx];
  assign rd_line1  = data_q[1][idx];
  assign rd_lru    = lru_q[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (wr_line_en) valid_q[wr_way][idx] <= 1'b1;
      if (lru_en)     lru_q[idx]           <= lru_val;
    end
  end

  // Tag and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_line_en) begin
      tag_q[wr_way][idx]  <= wr_tag;
      data_q[wr_way][idx] <= wr_line;
    end else if (wr_word_en) begin
      if (wr_word_sel) data_q[wr_way][idx][63:32] <= wr_word;
      else             data_q[wr_way][idx][31:0]  <= wr_word;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller. Read hits complete in the request
// cycle; read misses and all stores hold ready low until sram_ready.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rd_en, wr_en        MEM-stage load / store request (wr_en wins if both)
//   addr, wdata         byte address (word aligned) and store data
//   rdata, ready        load data (0 unless a load completes) and completion
//   sram_rd_en/wr_en    line read / word write request to the SRAM controller
//   sram_addr, sram_wdata, sram_rdata, sram_ready   SRAM side
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned SETS      = 64,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  state_t state_q, state_d;

  logic [31:0]      rel_addr;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;

  logic             valid0, valid1, lru;
  logic [TAG_W-1:0] tag0, tag1;
  logic [63:0]      line0, line1, hit_line;
  logic             hit0, hit1, hit, hit_way, victim;

  logic             wr_line_en, wr_word_en, wr_way, lru_en, lru_val;

  assign rel_addr = addr - BASE_ADDR;
  assign idx      = addr_index(rel_addr);
  assign tag      = addr_tag(rel_addr);
  assign word_sel = addr_word(rel_addr);

  cache_mem #(.SETS(SETS)) u_mem (
    .clk         (clk),
    .rst         (rst),
    .idx         (idx),
    .rd_valid0   (valid0),
    .rd_valid1   (valid1),
    .rd_tag0     (tag0),
    .rd_tag1     (tag1),
    .rd_line0    (line0),
    .rd_line1    (line1),
    .rd_lru      (lru),
    .wr_line_en  (wr_line_en),
    .wr_word_en  (wr_word_en),
    .wr_way      (wr_way),
    .wr_word_sel (word_sel),
    .wr_tag      (tag),
    .wr_line     (sram_rdata),
    .wr_word     (wdata),
    .lru_en      (lru_en),
    .lru_val     (lru_val)
  );

  assign hit0     = valid0 && (tag0 == tag);
  assign hit1     = valid1 && (tag1 == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1 && !hit0;
  assign hit_line = hit_way ? line1 : line0;

  // Invalid way first (way 0 preferred), otherwise the LRU way.
  assign victim = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b1;
    rdata      = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    wr_line_en = 1'b0;
    wr_word_en = 1'b0;
    wr_way     = hit_way;
    lru_en     = 1'b0;
    lru_val    = ~hit_way;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          ready   = 1'b0;
          state_d = WRITE;
          if (hit) begin
            wr_word_en = 1'b1;
            lru_en     = 1'b1;
          end
        end else if (rd_en) begin
          if (hit) begin
            rdata  = word_sel ? hit_line[63:32] : hit_line[31:0];
            lru_en = 1'b1;
          end else begin
            ready   = 1'b0;
            state_d = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        sram_rd_en = 1'b1;
        ready      = 1'b0;
        if (sram_ready) begin
          ready      = 1'b1;
          wr_line_en = 1'b1;
          wr_way     = victim;
          lru_en     = 1'b1;
          lru_val    = ~victim;
          state_d    = IDLE;
          if (rd_en) rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
        end
      end
      WRITE: begin
        sram_wr_en = 1'b1;
        ready      = 1'b0;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_addr  = (state_q == READ_MISS) ? {addr[31:3], 3'b000} : addr;
  assign sram_wdata = wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios followed by
// randomized loads/stores, checked against a set-associative reference model.
module tb_cache_controller;

  localparam int unsigned SETS = 64;
  localparam bit [31:0]   BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, rdata, sram_addr, sram_wdata;
  logic        ready, sram_rd_en, sram_wr_en, sram_ready;
  logic [63:0] sram_rdata;

  always #5 clk = ~clk;

  cache_controller #(.SETS(SETS), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: contents of each set as the specification describes it.
  bit        m_valid [SETS][2];
  bit [9:0]  m_tag   [SETS][2];
  bit [31:0] m_data  [SETS][2][2];
  bit        m_lru   [SETS];
  bit [31:0] sram_mem [bit [31:0]];

  function automatic bit [31:0] mem_word(input bit [31:0] wa);
    if (sram_mem.exists(wa)) return sram_mem[wa];
    return wa * 32'h9E37_79B1 + 32'd1;
  endfunction

  function automatic int set_of(input bit [31:0] ad);
    return int'(((ad - BASE) / 8) % SETS);
  endfunction

  function automatic bit [9:0] tag_of(input bit [31:0] ad);
    return 10'(((ad - BASE) / 512) % 1024);
  endfunction

  function automatic int word_of(input bit [31:0] ad);
    return int'(((ad - BASE) / 4) % 2);
  endfunction

  function automatic int lookup(input bit [31:0] ad);
    int s;
    s = set_of(ad);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(ad)) return w;
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s]      = 1'b0;
    end
  endtask

  // Every transaction task starts and ends 1 time unit after a rising edge.
  task automatic do_read(input bit [31:0] ad, input int lat, input string nm);
    int s, w, ws, v;
    bit [31:0] line;
    s  = set_of(ad);
    ws = word_of(ad);
    line = {ad[31:3], 3'b000};
    rd_en = 1'b1; wr_en = 1'b0; addr = ad; sram_ready = 1'b0;
    @(negedge clk);
    w = lookup(ad);
    if (w >= 0) begin
      check({nm, "_hit_ready"}, ready, 1);
      check({nm, "_hit_rdata"}, rdata, m_data[s][w][ws]);
      check({nm, "_hit_nosram"}, {sram_rd_en, sram_wr_en}, 0);
      @(posedge clk);
      m_lru[s] = (w == 0);
      #1;
    end else begin
      check({nm, "_miss_ready"}, ready, 0);
      check({nm, "_miss_rdata0"}, rdata, 0);
      @(posedge clk); #1;
      for (int k = 0; k < lat; k++) begin
        if (k == lat - 1) begin
          sram_ready = 1'b1;
          sram_rdata = {mem_word(line + 4), mem_word(line)};
        end
        @(negedge clk);
        check({nm, "_rd_req"}, {sram_rd_en, sram_wr_en}, 2'b10);
        check({nm, "_rd_addr"}, sram_addr, line);
        check({nm, "_rd_ready"}, ready, (k == lat - 1));
        check({nm, "_rd_rdata"}, rdata, (k == lat - 1) ? mem_word(ad) : 0);
        @(posedge clk); #1;
      end
      v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : int'(m_lru[s]));
      m_valid[s][v]   = 1'b1;
      m_tag[s][v]     = tag_of(ad);
      m_data[s][v][0] = mem_word(line);
      m_data[s][v][1] = mem_word(line + 4);
      m_lru[s]        = (v == 0);
      sram_ready = 1'b0;
      sram_rdata = '0;
    end
    rd_en = 1'b0;
  endtask

  task automatic do_write(input bit [31:0] ad, input bit [31:0] d, input int lat,
                          input bit also_rd, input string nm);
    int s, w;
    s = set_of(ad);
    rd_en = also_rd; wr_en = 1'b1; addr = ad; wdata = d; sram_ready = 1'b0;
    @(negedge clk);
    w = lookup(ad);
    check({nm, "_req_ready"}, ready, 0);
    check({nm, "_req_nord"}, sram_rd_en, 0);
    check({nm, "_req_rdata0"}, rdata, 0);
    @(posedge clk);
    if (w >= 0) begin
      m_data[s][w][word_of(ad)] = d;
      m_lru[s] = (w == 0);
    end
    #1;
    for (int k = 0; k < lat; k++) begin
      if (k == lat - 1) sram_ready = 1'b1;
      @(negedge clk);
      check({nm, "_wr_req"}, {sram_rd_en, sram_wr_en}, 2'b01);
      check({nm, "_wr_addr"}, sram_addr, ad);
      check({nm, "_wr_data"}, sram_wdata, d);
      check({nm, "_wr_ready"}, ready, (k == lat - 1));
      @(posedge clk); #1;
    end
    sram_mem[ad] = d;
    sram_ready = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic reset_mid_miss(input bit [31:0] ad);
    rd_en = 1'b1; wr_en = 1'b0; addr = ad; sram_ready = 1'b0;
    @(negedge clk);
    check("rstmiss_start_ready", ready, (lookup(ad) >= 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmiss_rd_req", sram_rd_en, 1);
    #1;
    rst = 1'b1; rd_en = 1'b0;
    #1;
    check("rstmiss_rd_drop", sram_rd_en, 0);
    check("rstmiss_ready", ready, 1);
    check("rstmiss_rdata", rdata, 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [31:0] ad;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = BASE; wdata = '0;
    sram_ready = 1'b0; sram_rdata = '0;
    model_clear();
    #2;
    check("reset_ready", ready, 1);
    check("reset_sram_req", {sram_rd_en, sram_wr_en}, 0);
    check("reset_rdata", rdata, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    sram_mem[32'd1024] = 32'd5;
    sram_mem[32'd1028] = 32'd7;
    do_read(32'd1024, 3, "cold1024");
    do_read(32'd1028, 1, "hit1028");
    do_write(32'd1024, 32'd8192, 2, 1'b0, "st_hit1024");
    do_read(32'd1024, 2, "rd_after_st");
    do_write(32'd1100, 32'h1234_5678, 2, 1'b0, "st_miss1100");
    do_read(32'd1100, 2, "rd1100_noalloc");
    do_read(32'd1536, 2, "lru1536");
    do_read(32'd2048, 3, "lru2048");
    do_read(32'd1536, 1, "lru1536_again");
    do_read(32'd1024, 2, "lru1024_evicted");
    reset_mid_miss(32'd3000);
    do_read(32'd3000, 2, "rd3000_after_rst");
    do_write(32'd4000, 32'hCAFE_F00D, 3, 1'b1, "rdwr_both");
    do_read(32'd4000, 1, "rd4000");

    for (int i = 0; i < 300; i++) begin
      ad = BASE + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
                + ($urandom_range(0, 1) << 2);
      if ($urandom_range(0, 9) < 7)
        do_read(ad, int'($urandom_range(1, 4)), "rnd_rd");
      else
        do_write(ad, $urandom, int'($urandom_range(1, 4)), 1'b0, "rnd_wr");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
